// File: rtl/vec_dot_pipe.sv
// Pipelined LANES-wide dot-product engine: multiply, reduce, accumulate/output.
// Define DOTP_ACCUM_EN to accumulate multi-beat packets delimited by in_last.
module vec_dot_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES*WIDTH-1:0]  a_vec,
  input  logic [LANES*WIDTH-1:0]  b_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [15:0]             out_beats
);

  localparam int unsigned CW = 16;

  logic             advance;
  logic [WIDTH-1:0] p [LANES];
  logic             v1;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] s2;
  logic             v2;

  // Whole pipeline moves as one; a stalled result freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef DOTP_ACCUM_EN
  logic          last1;
  logic          last2;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0] cnt;
`else
  logic unused_last;
  assign unused_last = in_last;
`endif

  // S1: per-lane products, low WIDTH bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) p[i] <= '0;
`ifdef DOTP_ACCUM_EN
      last1 <= 1'b0;
`endif
    end else if (advance) begin
      v1 <= in_valid;
      for (int i = 0; i < int'(LANES); i++)
        p[i] <= a_vec[i*WIDTH +: WIDTH] * b_vec[i*WIDTH +: WIDTH];
`ifdef DOTP_ACCUM_EN
      last1 <= in_last;
`endif
    end
  end

  // S2: lane reduction
  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(LANES); i++) sum = sum + p[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      s2 <= '0;
`ifdef DOTP_ACCUM_EN
      last2 <= 1'b0;
`endif
    end else if (advance) begin
      v2 <= v1;
      s2 <= sum;
`ifdef DOTP_ACCUM_EN
      last2 <= last1;
`endif
    end
  end

  // S3: accumulate partial sums, emit on the last beat of a packet
`ifdef DOTP_ACCUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (advance) begin
      if (v2 && last2) begin
        out_data  <= acc + s2;
        out_beats <= (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        out_valid <= 1'b0;
        if (v2) begin
          acc <= acc + s2;
          cnt <= (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        out_data  <= s2;
        out_beats <= CW'(1);
      end
    end
  end
`endif

endmodule
